// File: rtl/adc_packetizer.sv
// Packs a free-running 32-bit ADC sample stream into triggered 512-bit Avalon-ST packets.
// Beats completed while the output register is still occupied are dropped and counted.
module adc_packetizer #(
  parameter int unsigned SAMPLES_PER_BEAT = 16,
  parameter int unsigned LEN_W            = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           arm,
  input  logic [LEN_W-1:0]               pkt_len,
  input  logic                           trigger,
  input  logic [31:0]                    sample_data,
  input  logic                           sample_valid,
  output logic [32*SAMPLES_PER_BEAT-1:0] st_data,
  output logic                           st_valid,
  input  logic                           st_ready,
  output logic                           st_startofpacket,
  output logic                           st_endofpacket,
  output logic [5:0]                     st_empty,
  output logic                           busy,
  output logic                           overflow,
  input  logic                           clr_overflow,
  output logic [LEN_W-1:0]               drop_count
);

  localparam int unsigned IDX_W = $clog2(SAMPLES_PER_BEAT);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t                                 state, state_nxt;
  logic [LEN_W-1:0]                       remaining;
  logic [IDX_W-1:0]                       idx;
  logic [IDX_W-1:0]                       slot_sel;
  logic [SAMPLES_PER_BEAT-1:0][31:0]      beat_buf, beat_merged;
  logic                                   first_beat;
  logic                                   arm_ok, take, last, complete, load;
  logic [5:0]                             empty_nxt;

  always_comb begin
    arm_ok   = (state == IDLE) && arm && (pkt_len != '0);
    take     = sample_valid && ((state == CAPTURE) || ((state == ARMED) && trigger));
    last     = (remaining == LEN_W'(1));
    complete = take && ((idx == IDX_W'(SAMPLES_PER_BEAT - 1)) || last);
    load     = complete && (!st_valid || st_ready);
    // Slot 0 lives in the most significant word, so packed index runs backwards.
    slot_sel = IDX_W'(SAMPLES_PER_BEAT - 1) - idx;
    beat_merged           = beat_buf;
    beat_merged[slot_sel] = sample_data;
    empty_nxt = last ? 6'({slot_sel, 2'b00}) : '0;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arm_ok) state_nxt = ARMED;
      ARMED:   if (trigger) state_nxt = CAPTURE;
      CAPTURE: state_nxt = CAPTURE;
      default: state_nxt = IDLE;
    endcase
    if (take && last) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Buffer is cleared at every beat boundary so unused slots of a short eop beat read 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining  <= '0;
      idx        <= '0;
      beat_buf   <= '0;
      first_beat <= 1'b0;
    end else if (arm_ok) begin
      remaining  <= pkt_len;
      idx        <= '0;
      beat_buf   <= '0;
      first_beat <= 1'b1;
    end else if (take) begin
      remaining <= remaining - LEN_W'(1);
      if (complete) begin
        idx        <= '0;
        beat_buf   <= '0;
        first_beat <= 1'b0;
      end else begin
        idx      <= idx + IDX_W'(1);
        beat_buf <= beat_merged;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_valid         <= 1'b0;
      st_data          <= '0;
      st_startofpacket <= 1'b0;
      st_endofpacket   <= 1'b0;
      st_empty         <= '0;
    end else if (load) begin
      st_valid         <= 1'b1;
      st_data          <= beat_merged;
      st_startofpacket <= first_beat;
      st_endofpacket   <= last;
      st_empty         <= empty_nxt;
    end else if (st_ready) begin
      st_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (complete && !load) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + LEN_W'(1);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_adc_packetizer.sv
// Directed bench for adc_packetizer: table of packet scenarios plus hand-written
// backpressure, reject/ignore and mid-packet reset sequences.
module tb_adc_packetizer;

  logic         clk = 1'b0;
  logic         reset, arm, trigger, sample_valid, st_ready, clr_overflow;
  logic [15:0]  pkt_len;
  logic [31:0]  sample_data;
  logic [511:0] st_data;
  logic         st_valid, st_startofpacket, st_endofpacket, busy, overflow;
  logic [5:0]   st_empty;
  logic [15:0]  drop_count;

  always #5 clk = ~clk;

  adc_packetizer #(.SAMPLES_PER_BEAT(16), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .arm(arm), .pkt_len(pkt_len), .trigger(trigger),
    .sample_data(sample_data), .sample_valid(sample_valid), .st_data(st_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_startofpacket(st_startofpacket),
    .st_endofpacket(st_endofpacket), .st_empty(st_empty), .busy(busy),
    .overflow(overflow), .clr_overflow(clr_overflow), .drop_count(drop_count)
  );

  typedef struct {
    int unsigned len;
    logic [31:0] base;
    int          gap_at;
    int          arm_at;
    int unsigned exp_beats;
    logic [5:0]  exp_empty;
  } vec_t;

  typedef struct {
    logic [511:0] d;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  vec_t  vt[7];

  always @(negedge clk)
    if (st_valid && st_ready) q.push_back('{st_data, st_startofpacket, st_endofpacket, st_empty});

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_beat(input int unsigned len, input logic [31:0] base,
                                            input int unsigned b);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      int unsigned s;
      s = 16 * b + k;
      if (s < len) r[511-32*k -: 32] = base + s;
    end
    return r;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, " st_valid"}, st_valid, 0);
    chk({tag, " st_data"}, st_data, 0);
    chk({tag, " sop"}, st_startofpacket, 0);
    chk({tag, " eop"}, st_endofpacket, 0);
    chk({tag, " empty"}, st_empty, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " overflow"}, overflow, 0);
    chk({tag, " drop_count"}, drop_count, 0);
  endtask

  task automatic start_pkt(input int unsigned len);
    @(negedge clk);
    pkt_len = 16'(len);
    arm     = 1'b1;
    @(negedge clk);
    arm     = 1'b0;
    pkt_len = '0;
  endtask

  task automatic run_packet(input vec_t v);
    int s, cyc, nb;
    st_ready = 1'b1;
    q.delete();
    start_pkt(v.len);
    chk($sformatf("len%0d busy after arm", v.len), busy, 1);
    trigger = 1'b1;
    s = 0;
    cyc = 0;
    while (s < int'(v.len)) begin
      if (cyc == v.gap_at) begin
        sample_valid = 1'b0;
      end else begin
        sample_valid = 1'b1;
        sample_data  = v.base + 32'(s);
        s++;
      end
      if (cyc == v.arm_at) begin
        arm     = 1'b1;
        pkt_len = 16'd3;
      end
      @(negedge clk);
      trigger = 1'b0;
      arm     = 1'b0;
      pkt_len = '0;
      cyc++;
    end
    sample_valid = 1'b0;
    chk($sformatf("len%0d eop latency", v.len), {st_valid, st_endofpacket}, 2'b11);
    chk($sformatf("len%0d busy after last", v.len), busy, 0);
    repeat (3) @(negedge clk);
    chk($sformatf("len%0d beat count", v.len), q.size(), v.exp_beats);
    nb = (q.size() < int'(v.exp_beats)) ? q.size() : int'(v.exp_beats);
    for (int b = 0; b < nb; b++) begin
      chk($sformatf("len%0d beat%0d data", v.len, b), q[b].d, exp_beat(v.len, v.base, b));
      chk($sformatf("len%0d beat%0d sop", v.len, b), q[b].sop, (b == 0));
      chk($sformatf("len%0d beat%0d eop", v.len, b), q[b].eop, (b == nb - 1));
      chk($sformatf("len%0d beat%0d empty", v.len, b), q[b].empty,
          (b == nb - 1) ? v.exp_empty : 6'd0);
    end
  endtask

  initial begin
    vt[0] = '{5,  32'h1,    -1, -1, 1, 6'd44};
    vt[1] = '{40, 32'h100,  -1, -1, 3, 6'd32};
    vt[2] = '{32, 32'h200,  -1, -1, 2, 6'd0};
    vt[3] = '{17, 32'h400,   9, -1, 2, 6'd60};
    vt[4] = '{1,  32'h500,  -1, -1, 1, 6'd60};
    vt[5] = '{20, 32'h600,  -1,  5, 2, 6'd48};
    vt[6] = '{16, 32'hA000, -1, -1, 1, 6'd0};

    reset = 1'b1; arm = 1'b0; trigger = 1'b0; sample_valid = 1'b0; st_ready = 1'b1;
    clr_overflow = 1'b0; pkt_len = '0; sample_data = '0;
    repeat (2) @(negedge clk);
    check_reset("por");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_packet(vt[i]);

    // zero-length arm is rejected; trigger while idle is ignored
    q.delete();
    @(negedge clk);
    pkt_len = '0;
    arm     = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk("zero len busy", busy, 0);
    trigger      = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 32'hDEAD;
    @(negedge clk);
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    sample_valid = 1'b0;
    chk("idle trigger busy", busy, 0);
    chk("idle trigger st_valid", st_valid, 0);
    chk("idle trigger beats", q.size(), 0);

    // backpressure: beat 0 held, beats 1 and 2 dropped
    st_ready = 1'b0;
    start_pkt(48);
    trigger = 1'b1;
    for (int s = 0; s < 48; s++) begin
      sample_valid = 1'b1;
      sample_data  = 32'h3000 + 32'(s);
      @(negedge clk);
      trigger = 1'b0;
      if (s == 15) chk("bp beat0 valid", st_valid, 1);
      if (s == 31) chk("bp first drop count", drop_count, 1);
    end
    sample_valid = 1'b0;
    chk("bp held data", st_data, exp_beat(48, 32'h3000, 0));
    chk("bp held sop/eop", {st_startofpacket, st_endofpacket}, 2'b10);
    chk("bp held empty", st_empty, 0);
    chk("bp overflow", overflow, 1);
    chk("bp drop_count", drop_count, 2);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("clr overflow", overflow, 0);
    chk("clr drop_count", drop_count, 0);

    // clear coinciding with a drop wins
    start_pkt(32);
    trigger = 1'b1;
    for (int s = 0; s < 32; s++) begin
      sample_valid = 1'b1;
      sample_data  = 32'h4000 + 32'(s);
      clr_overflow = (s == 31);
      @(negedge clk);
      trigger = 1'b0;
      if (s == 20) chk("bp2 drop_count mid", drop_count, 1);
    end
    sample_valid = 1'b0;
    clr_overflow = 1'b0;
    chk("clr priority overflow", overflow, 0);
    chk("clr priority drop_count", drop_count, 0);
    chk("bp2 still holds beat0", st_data, exp_beat(48, 32'h3000, 0));
    st_ready = 1'b1;
    @(negedge clk);
    chk("drain st_valid", st_valid, 0);

    // reset mid-packet with a pending beat and a partial beat
    st_ready = 1'b0;
    start_pkt(40);
    trigger = 1'b1;
    for (int s = 0; s < 20; s++) begin
      sample_valid = 1'b1;
      sample_data  = 32'h5000 + 32'(s);
      @(negedge clk);
      trigger = 1'b0;
    end
    sample_valid = 1'b0;
    chk("pre-reset pending", st_valid, 1);
    reset = 1'b1;
    #1;
    check_reset("mid reset");
    @(negedge clk);
    reset = 1'b0;
    run_packet(vt[6]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
